// File: rtl/cordic_phase_discr.sv
// Phase discriminator: wrapped phase step between consecutive CORDIC samples, averaged over 2^AVG_LOG2 samples.
// Optional squelch on low magnitude is enabled by defining CPD_SQUELCH_EN.
module cordic_phase_discr #(
    parameter int XY_WIDTH = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       st,
    input  logic [XY_WIDTH-1:0]        mag,
    input  logic signed [XY_WIDTH+1:0] ph,
    input  logic [XY_WIDTH-1:0]        thr,
    output logic                       rdy,
    output logic signed [XY_WIDTH+1:0] freq,
    output logic                       sq
);

    localparam int PW = XY_WIDTH + 2;
    localparam int DW = XY_WIDTH + 3;
    localparam int AW = PW + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic signed [DW-1:0] PI_W     = {3'b001, {XY_WIDTH{1'b0}}};
    localparam logic signed [DW-1:0] TWO_PI_W = {3'b010, {XY_WIDTH{1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic signed [PW-1:0]   ph_prev_q, ph_prev_d;
    logic                   primed_q, primed_d;
    logic signed [PW-1:0]   d1_q, d1_d;
    logic                   v1_q, v1_d;
    logic                   s1_q, s1_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sqacc_q, sqacc_d;
    logic signed [PW-1:0]   freq_q, freq_d;
    logic                   sq_q, sq_d;
    logic                   rdy_q, rdy_d;
    logic                   smp_sq;
    logic signed [DW-1:0]   diff_raw, diff_wrap;
    logic signed [AW-1:0]   d_ext, acc_sum;

`ifdef CPD_SQUELCH_EN
    assign smp_sq = (mag < thr);
`else
    logic unused_sq_inputs;
    assign unused_sq_inputs = ^{mag, thr};
    assign smp_sq = 1'b0;
`endif

    // Difference at one extra bit, folded back into (-pi, pi]; exact -pi becomes +pi.
    always_comb begin
        diff_raw  = $signed({ph[PW-1], ph}) - $signed({ph_prev_q[PW-1], ph_prev_q});
        diff_wrap = diff_raw;
        if (diff_raw > PI_W) begin
            diff_wrap = diff_raw - TWO_PI_W;
        end else if (diff_raw <= -PI_W) begin
            diff_wrap = diff_raw + TWO_PI_W;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_prev_d = ph_prev_q;
        primed_d  = primed_q;
        d1_d      = '0;
        v1_d      = 1'b0;
        s1_d      = 1'b0;
        if (clr) begin
            state_d  = IDLE;
            primed_d = 1'b0;
        end else if (st) begin
            if (state_q == IDLE) begin
                if (!smp_sq) begin
                    ph_prev_d = ph;
                    primed_d  = 1'b1;
                    state_d   = RUN;
                end
            end else begin
                v1_d = 1'b1;
                if (smp_sq) begin
                    primed_d = 1'b0;
                    s1_d     = 1'b1;
                end else begin
                    ph_prev_d = ph;
                    primed_d  = 1'b1;
                    if (primed_q) begin
                        d1_d = diff_wrap[PW-1:0];
                    end
                end
            end
        end
    end

    assign d_ext   = AW'(d1_q);
    assign acc_sum = acc_q + d_ext;

    // The closing sample is folded into the output directly so the next window starts clean.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sqacc_d = sqacc_q;
        freq_d  = freq_q;
        sq_d    = sq_q;
        rdy_d   = 1'b0;
        if (clr) begin
            acc_d   = '0;
            cnt_d   = '0;
            sqacc_d = 1'b0;
        end else if (v1_q) begin
            if (cnt_q == CNT_LAST) begin
                freq_d  = PW'(acc_sum >>> AVG_LOG2);
                sq_d    = sqacc_q | s1_q;
                rdy_d   = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                sqacc_d = 1'b0;
            end else begin
                acc_d   = acc_sum;
                cnt_d   = cnt_q + CW'(1);
                sqacc_d = sqacc_q | s1_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ph_prev_q <= '0;
            primed_q  <= 1'b0;
            d1_q      <= '0;
            v1_q      <= 1'b0;
            s1_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sqacc_q   <= 1'b0;
            freq_q    <= '0;
            sq_q      <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_prev_q <= ph_prev_d;
            primed_q  <= primed_d;
            d1_q      <= d1_d;
            v1_q      <= v1_d;
            s1_q      <= s1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sqacc_q   <= sqacc_d;
            freq_q    <= freq_d;
            sq_q      <= sq_d;
            rdy_q     <= rdy_d;
        end
    end

    assign rdy  = rdy_q;
    assign freq = freq_q;
    assign sq   = sq_q;

endmodule

// File: tb/tb_cordic_phase_discr.sv
// Directed bench for cordic_phase_discr: one instance with AVG_LOG2=0, one with AVG_LOG2=2, scoreboard per instance.
module tb_cordic_phase_discr;

    typedef struct {
        int f;
        bit s;
        int c;
    } exp_t;

`ifdef CPD_SQUELCH_EN
    localparam int SQ_F = 150;
    localparam bit SQ_S = 1'b1;
`else
    localparam int SQ_F = 300;
    localparam bit SQ_S = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               clr0, clr2, st0, st2;
    logic [15:0]        mag_in, thr_in;
    logic signed [17:0] ph_in;
    logic               rdy0, rdy2, sq0, sq2;
    logic signed [17:0] freq0, freq2;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q0[$];
    exp_t q2[$];

    cordic_phase_discr #(.XY_WIDTH(16), .AVG_LOG2(0)) u0 (
        .clk(clk), .reset(reset), .clr(clr0), .st(st0), .mag(mag_in), .ph(ph_in),
        .thr(thr_in), .rdy(rdy0), .freq(freq0), .sq(sq0)
    );

    cordic_phase_discr #(.XY_WIDTH(16), .AVG_LOG2(2)) u2 (
        .clk(clk), .reset(reset), .clr(clr2), .st(st2), .mag(mag_in), .ph(ph_in),
        .thr(thr_in), .rdy(rdy2), .freq(freq2), .sq(sq2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rdy0 === 1'b1) begin
            chk("rdy0_expected", q0.size() > 0, 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("freq0", freq0, e.f);
                chk("sq0", sq0, e.s);
                chk("rdy0_cycle", cyc, e.c);
                $display("u0 rdy: freq=%0d sq=%0d cyc=%0d", freq0, sq0, cyc);
            end
        end
        if (rdy2 === 1'b1) begin
            chk("rdy2_expected", q2.size() > 0, 1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("freq2", freq2, e.f);
                chk("sq2", sq2, e.s);
                chk("rdy2_cycle", cyc, e.c);
                $display("u2 rdy: freq=%0d sq=%0d cyc=%0d", freq2, sq2, cyc);
            end
        end
    end

    task automatic step(input int which, input int p, input bit push = 1'b0, input int ef = 0,
                        input bit es = 1'b0, input bit c = 1'b0, input int m = 500);
        exp_t e;
        @(negedge clk);
        st0    = (which == 0);
        st2    = (which == 2);
        clr0   = c && (which == 0);
        clr2   = c && (which == 2);
        ph_in  = p[17:0];
        mag_in = m[15:0];
        if (push) begin
            e.f = ef;
            e.s = es;
            e.c = cyc + 2;
            if (which == 0) q0.push_back(e);
            else q2.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            st0 = 1'b0; st2 = 1'b0; clr0 = 1'b0; clr2 = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        clr0 = 1'b0; clr2 = 1'b0; st0 = 1'b0; st2 = 1'b0;
        mag_in = 16'd500; thr_in = 16'd100; ph_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rdy0", rdy0, 0);
        chk("reset_freq0", freq0, 0);
        chk("reset_sq0", sq0, 0);
        chk("reset_rdy2", rdy2, 0);
        chk("reset_freq2", freq2, 0);
        chk("reset_sq2", sq2, 0);

        // Constant rotation, wraps in both directions, exact -pi and +pi.
        step(0, 0);
        step(0, 1000, 1, 1000);
        step(0, 2000, 1, 1000);
        step(0, 3000, 1, 1000);
        step(0, 60000, 1, 57000);
        step(0, -60000, 1, 11072);
        step(0, 60000, 1, -11072);
        step(0, -5536, 1, 65536);
        step(0, 60000, 1, 65536);
        idle(3);

        // Restart with a result in flight, then clr together with st.
        step(0, 500, 1, -59500);
        step(0, 600, 1, 100);
        step(0, 700);
        step(0, 800, 0, 0, 0, 1);
        step(0, 900);
        step(0, 950, 1, 50);
        idle(3);

        // Averaging windows, back to back, including floor of negative means.
        step(2, 0);
        step(2, 5);
        step(2, 11);
        step(2, 18);
        step(2, 27, 1, 6);
        step(2, 26);
        step(2, 26);
        step(2, 26);
        step(2, 26, 1, -1);
        step(2, 36);
        step(2, 46);
        step(2, 56);
        step(2, 66, 1, 10);
        step(2, 76);
        step(2, 86);
        step(2, 96);
        step(2, 106, 1, 10);
        step(2, 101);
        step(2, 96);
        step(2, 91);
        step(2, 85, 1, -6);
        idle(3);

        // Squelch window (thr is ignored when the feature is not built).
        @(negedge clk);
        st0 = 1'b0; st2 = 1'b0; clr0 = 1'b0; clr2 = 1'b1;
        step(2, 0);
        step(2, 300);
        step(2, 600, 0, 0, 0, 0, 50);
        step(2, 900);
        step(2, 1200, 1, SQ_F, SQ_S);
        step(2, 1500);

        // Mid-window clr with st discards the partial window; next sample only primes.
        step(2, 1600, 0, 0, 0, 1);
        step(2, 1000);
        step(2, 1004);
        step(2, 1008);
        step(2, 1012);
        step(2, 1016, 1, 4);
        idle(4);
        chk("freq2_hold", freq2, 4);
        chk("freq0_hold", freq0, 50);

        // Asynchronous reset mid-window.
        step(2, 1020);
        step(2, 1024);
        @(posedge clk);
        #2;
        reset = 1'b1;
        st2 = 1'b0;
        #1;
        chk("areset_rdy2", rdy2, 0);
        chk("areset_freq2", freq2, 0);
        chk("areset_sq2", sq2, 0);
        chk("areset_freq0", freq0, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        step(2, 0);
        step(2, 7);
        step(2, 14);
        step(2, 21);
        step(2, 28, 1, 7);
        idle(4);

        chk("q0_drained", q0.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cordic_phase_discr.md
# cordic_phase_discr

Phase discriminator placed directly downstream of the parallel CORDIC magnitude/phase pipeline. It consumes the `rdy`/`mag`/`ph` stream, forms the wrapped phase difference between consecutive samples (instantaneous frequency), and averages it over 2^AVG_LOG2 samples. It emits one frequency word per window for FM demodulation and carrier-offset estimation.

## Interface
Parameters:
- XY_WIDTH, 16, width of upstream `mag`; the phase and frequency words are XY_WIDTH+2 bits wide.
- AVG_LOG2, 2, log2 of the averaging window. 0 means one output per difference.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous restart, returns the block to IDLE.
- st  in  1  sample valid; driven by upstream `rdy`; one-cycle strobe, may be asserted every cycle.
- mag  in  XY_WIDTH  unsigned magnitude.
- ph  in  XY_WIDTH+2  signed phase; +pi = 0100..0 = 2^XY_WIDTH; range (-pi, pi].
- thr  in  XY_WIDTH  squelch threshold; used only when CPD_SQUELCH_EN is defined.
- rdy  out  1  one-cycle strobe; `freq` and `sq` are valid while it is high.
- freq  out  XY_WIDTH+2  signed mean phase step per sample; same scale as `ph`.
- sq  out  1  set when at least one sample in the window was squelched.

## Operation
- States:
  - IDLE (after reset or `clr`): the first `st` stores `ph` in `phPrev`, sets `primed`, moves to RUN, and is not counted.
  - RUN: every `st` is counted.
- Difference:
  - d = ph − phPrev, computed at XY_WIDTH+3 bits.
  - If d > 2^XY_WIDTH: d −= 2^(XY_WIDTH+1).
  - If d ≤ −2^XY_WIDTH: d += 2^(XY_WIDTH+1).
  - Result range is (−pi, pi]; an exact −pi maps to +pi. It fits XY_WIDTH+2 bits.
- Unprimed sample in RUN: contributes d = 0, then sets `primed`.
- Every sample that is not squelched updates `phPrev`.
- Accumulator:
  - Width XY_WIDTH+2+AVG_LOG2, so it never overflows.
  - Counter is AVG_LOG2 bits.
  - On the sample that completes the window: freq = (acc + d) >>> AVG_LOG2 (arithmetic shift, floor). The accumulator then restarts from 0 with no dropped sample.
- `sq` accumulates an OR over the window and clears when the window closes.
- `clr`:
  - Clears acc, count, `primed` and the sq accumulation, and returns to IDLE.
  - Suppresses any `rdy` in flight.
  - `clr` and `st` in the same cycle: `clr` wins and the sample is discarded.

## Timing
- Two-stage pipeline:
  - Stage 1 registers d and a valid bit.
  - Stage 2 accumulates and registers `freq`/`sq`/`rdy`.
- Latency: `rdy` rises 2 clk after the `st` that completes the window.
- Throughput: one sample per clk, sustained.
- Output cadence: exactly one `rdy` per 2^AVG_LOG2 counted samples.
- `freq` and `sq` hold their value between `rdy` strobes.
- Reset values: rdy = 0, freq = 0, sq = 0, state IDLE, phPrev = 0, acc = 0, count = 0.
- Reset may be asserted asynchronously mid-window. The partial window is lost and no `rdy` follows.

## Configuration
- CPD_SQUELCH_EN defined:
  - A sample with mag < thr is squelched: it contributes d = 0, does not update `phPrev`, clears `primed`, and sets the sq accumulation.
  - The next unsquelched sample contributes 0 and re-primes.
  - Squelched samples still count toward the window, so cadence is unchanged.
  - A squelched first sample in IDLE leaves the block in IDLE.
- CPD_SQUELCH_EN undefined:
  - `thr` is ignored.
  - `sq` is tied to 0.
  - All samples are treated as valid.

## Test plan
All scenarios use XY_WIDTH = 16 unless stated.
- Constant rotation: AVG_LOG2 = 0, ph = 0, 1000, 2000, 3000 on consecutive cycles -> three `rdy` strobes, freq = 1000 each, first at 2 clk after the second `st`.
- Wrap, positive direction: ph 60000 then −60000 -> freq = 11072.
- Wrap, negative direction: ph −60000 then 60000 -> freq = −11072.
- Exact −pi: step of exactly −65536 -> freq = +65536.
- Averaging: AVG_LOG2 = 2, differences 5, 6, 7, 9 (sum 27) -> one `rdy` with freq = 6. Differences −1, 0, 0, 0 -> freq = −1. Back-to-back `st` produces no gaps and exactly one `rdy` per 4 counted samples.
- Squelch (CPD_SQUELCH_EN): thr = 100, AVG_LOG2 = 2, mags 500, 500, 50, 500, 500, 500 with ph stepping by 300 -> window differences 300, 0, 0, 300 -> freq = 150, sq = 1.
- Restart: `clr` asserted with `st` mid-window -> no `rdy`; the next sample primes with no output.
- Async reset: reset asserted mid-window -> outputs return to 0 immediately.
